keypad_scanner: RTL and testbench

- Scans a 4x4 hex keypad matrix and debounces it. This is the user-input counterpart of the multiplexed 7-segment display driver.
- Drives one active-low column at a time and reads four active-low, pulled-up row lines.
- On each debounced press, emits the hex key code and shifts it into a 16-bit value. That value feeds the display NUM input and the CPU I/O path.

---
 rtl/keypad_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low keypad matrix one column at a time, debounces
// presses and releases on a slow scan tick, and reports each accepted key.
// The key code is 4*row + column. Each accepted code is also shifted into a
// 16-bit entry register, newest digit in the low nibble.
//
// Ports
//   CLK        system clock, all logic on the rising edge
//   RST        asynchronous active-high reset
//   ROW[3:0]   keypad rows, active-low, asynchronous to CLK
//   CLR        synchronous clear of NUM (wins over a simultaneous key shift)
//   COL[3:0]   column drive, active-low, exactly one bit low
//   KEY_VALID  one-cycle pulse per accepted press
//   KEY_CODE   code of the last accepted key, held until the next press
//   NUM[15:0]  accumulated entry, newest digit in NUM[3:0]
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ROW,
  input  logic        CLR,
  output logic [3:0]  COL,
  output logic        KEY_VALID,
  output logic [3:0]  KEY_CODE,
  output logic [15:0] NUM
);

  localparam int             TW        = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(SCAN_DIV);
  localparam logic [7:0]     DB_LAST   = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic [3:0]    row_meta_r;
  logic [3:0]    row_sync_r;
  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [7:0]    db_cnt_r;
  logic [7:0]    db_cnt_nxt_s;
  logic [1:0]    row_idx_r;
  logic [1:0]    row_idx_nxt_s;
  logic [3:0]    col_r;
  logic [3:0]    col_nxt_s;
  logic          key_valid_r;
  logic [3:0]    key_code_r;
  logic [3:0]    key_code_nxt_s;
  logic [15:0]   num_r;

  // True when exactly one row line is low; chords and idle both read false.
  function automatic logic single_low(input logic [3:0] row);
    case (row)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  // Position of the low bit in a one-hot-low pattern (rows or columns).
  function automatic logic [1:0] low_index(input logic [3:0] pat);
    case (pat)
      4'b1110: low_index = 2'd0;
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

  // Row pattern that a held single key at row idx presents.
  function automatic logic [3:0] row_pattern(input logic [1:0] idx);
    row_pattern = ~(4'b0001 << idx);
  endfunction

  // Next active column: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] col_advance(input logic [3:0] col);
    col_advance = {col[2:0], col[3]};
  endfunction

  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= ROW;
      row_sync_r <= row_meta_r;
    end
  end

  // Free-running scan tick divider, wraps after SCAN_DIV.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Scanner FSM next-state, debounce count, column and code selection.
  always_comb begin
    state_nxt_s    = state_r;
    db_cnt_nxt_s   = db_cnt_r;
    row_idx_nxt_s  = row_idx_r;
    col_nxt_s      = col_r;
    key_code_nxt_s = key_code_r;
    case (state_r)
      SCAN: begin
        if (tick_s) begin
          if (single_low(row_sync_r)) begin
            // Column stays put so the same key is re-sampled while debouncing.
            row_idx_nxt_s = low_index(row_sync_r);
            db_cnt_nxt_s  = 8'd1;
            if (DB_LAST == 8'd1) begin
              state_nxt_s    = PRESSED;
              key_code_nxt_s = {low_index(row_sync_r), low_index(col_r)};
            end else begin
              state_nxt_s = DEBOUNCE;
            end
          end else begin
            col_nxt_s = col_advance(col_r);
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      DEBOUNCE: begin
        if (tick_s) begin
          if (row_sync_r == row_pattern(row_idx_r)) begin
            db_cnt_nxt_s = db_cnt_r + 8'd1;
            if (db_cnt_r + 8'd1 == DB_LAST) begin
              state_nxt_s    = PRESSED;
              key_code_nxt_s = {row_idx_r, low_index(col_r)};
            end else begin
              state_nxt_s = DEBOUNCE;
            end
          end else begin
            // Bounce or changed pattern: give up and move on to the next column.
            db_cnt_nxt_s = 8'd0;
            col_nxt_s    = col_advance(col_r);
            state_nxt_s  = SCAN;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      PRESSED: begin
        state_nxt_s  = RELEASE;
        db_cnt_nxt_s = 8'd0;
      end
      RELEASE: begin
        if (tick_s) begin
          if (row_sync_r == 4'hF) begin
            if (db_cnt_r + 8'd1 == DB_LAST) begin
              db_cnt_nxt_s = 8'd0;
              col_nxt_s    = col_advance(col_r);
              state_nxt_s  = SCAN;
            end else begin
              db_cnt_nxt_s = db_cnt_r + 8'd1;
            end
          end else begin
            // Key still down: restart the release count, never auto-repeat.
            db_cnt_nxt_s = 8'd0;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s  = SCAN;
        db_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // FSM state, debounce counter, latched row and column drive registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= SCAN;
      db_cnt_r  <= 8'd0;
      row_idx_r <= 2'd0;
      col_r     <= 4'b1110;
    end else begin
      state_r   <= state_nxt_s;
      db_cnt_r  <= db_cnt_nxt_s;
      row_idx_r <= row_idx_nxt_s;
      col_r     <= col_nxt_s;
    end
  end

  // Registered key outputs; valid/code land in the PRESSED cycle, NUM shifts as it ends.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      num_r       <= 16'h0000;
    end else begin
      key_valid_r <= (state_nxt_s == PRESSED);
      key_code_r  <= key_code_nxt_s;
      if (CLR) begin
        num_r <= 16'h0000;
      end else if (state_r == PRESSED) begin
        num_r <= {num_r[11:0], key_code_r};
      end else begin
        num_r <= num_r;
      end
    end
  end

  assign COL       = col_r;
  assign KEY_VALID = key_valid_r;
  assign KEY_CODE  = key_code_r;
  assign NUM       = num_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives a behavioural 4x4 keypad (a set of held keys wired to the scanned
// columns) and checks every accepted key against a queue of expected
// code/entry pairs filled when presses are issued.
module tb_keypad_scanner;

  logic        CLK;
  logic        RST;
  logic [3:0]  ROW;
  logic        CLR;
  logic [3:0]  COL;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic [15:0] NUM;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] num;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_item;
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          num_model = 0;
  logic [15:0] keys;

  keypad_scanner #(.SCAN_DIV(3), .DEBOUNCE_SCANS(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ROW       (ROW),
    .CLR       (CLR),
    .COL       (COL),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE),
    .NUM       (NUM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Keypad: key k sits at row k/4, column k%4; a row reads low when any held
  // key in it has its column driven low.
  always_comb begin
    ROW    = 4'hF;
    ROW[0] = ~|(keys[3:0]   & ~COL);
    ROW[1] = ~|(keys[7:4]   & ~COL);
    ROW[2] = ~|(keys[11:8]  & ~COL);
    ROW[3] = ~|(keys[15:12] & ~COL);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference: each accepted key appends one hex digit; only 4 digits are kept.
  task automatic expect_press(input logic [3:0] code, input bit cleared);
    exp_t e;
    if (cleared) num_model = 0;
    else num_model = (num_model * 16 + int'(code)) % 65536;
    e.code = code;
    e.num  = 16'(num_model);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int gap);
    expect_press(code, 1'b0);
    keys       = 16'h0000;
    keys[code] = 1'b1;
    cyc(hold);
    keys = 16'h0000;
    cyc(gap);
    wait_drain("press_drain");
  endtask

  // Monitor: every pulse must match the oldest expectation; entry checked a cycle later.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && KEY_VALID === 1'b1) begin
        check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_item = exp_q.pop_front();
          check("key_code", 32'(KEY_CODE), 32'(mon_item.code));
          @(negedge CLK);
          check("valid_one_cycle", 32'(KEY_VALID), 32'd0);
          check("num", 32'(NUM), 32'(mon_item.num));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] col_tab [4];
    logic [1:0] col_pos;
    logic [3:0] prev;
    int         last_chg;
    int         changes;
    bit         found;

    col_tab[0] = 4'b1110;
    col_tab[1] = 4'b1101;
    col_tab[2] = 4'b1011;
    col_tab[3] = 4'b0111;

    RST  = 1'b1;
    CLR  = 1'b0;
    keys = 16'h0000;
    cyc(3);
    check("rst_col", 32'(COL), 32'(4'b1110));
    check("rst_valid", 32'(KEY_VALID), 32'd0);
    check("rst_code", 32'(KEY_CODE), 32'd0);
    check("rst_num", 32'(NUM), 32'd0);

    // Idle scanning: column rotation every 4 clocks.
    @(negedge CLK);
    RST      = 1'b0;
    col_pos  = 2'd0;
    prev     = COL;
    last_chg = -1;
    for (int i = 1; i <= 26; i++) begin
      cyc(1);
      if (COL !== prev) begin
        col_pos = col_pos + 2'd1;
        check("idle_rotation", 32'(COL), 32'(col_tab[col_pos]));
        if (last_chg >= 0) check("idle_period", 32'(i - last_chg), 32'd4);
        last_chg = i;
        prev     = COL;
      end
    end
    check("idle_num", 32'(NUM), 32'd0);

    // Held key r=1,c=2: one pulse, column frozen until clean release.
    expect_press(4'h6, 1'b0);
    keys[6] = 1'b1;
    cyc(60);
    check("hold_drained", 32'(exp_q.size()), 32'd0);
    check("hold_col_a", 32'(COL), 32'(4'b1011));
    cyc(40);
    check("hold_col_b", 32'(COL), 32'(4'b1011));
    keys = 16'h0000;
    cyc(4);
    check("release_col_held", 32'(COL), 32'(4'b1011));
    cyc(10);
    check("release_col_moved", 32'(COL != 4'b1011), 32'd1);
    cyc(20);

    // Clear, then a digit sequence that overflows the entry by one nibble.
    CLR = 1'b1;
    cyc(1);
    CLR       = 1'b0;
    num_model = 0;
    check("clr_num", 32'(NUM), 32'd0);
    press(4'h1, 60, 30);
    press(4'h2, 60, 30);
    press(4'h3, 60, 30);
    press(4'h4, 60, 30);
    press(4'hF, 60, 30);
    check("seq_num", 32'(NUM), 32'(16'h234F));

    // Bounce: key r=2,c=1 low on exactly one tick.
    found = 1'b0;
    prev  = COL;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (COL == 4'b1101 && prev != 4'b1101) found = 1'b1;
      prev = COL;
    end
    check("bounce_col_found", 32'(found), 32'd1);
    keys[9] = 1'b1;
    cyc(4);
    check("bounce_col_held", 32'(COL), 32'(4'b1101));
    keys = 16'h0000;
    cyc(4);
    check("bounce_next_col", 32'(COL), 32'(4'b1011));
    cyc(20);

    // Chord in column 0 (rows 0 and 1): ignored, scanning keeps moving.
    keys    = 16'h0011;
    changes = 0;
    prev    = COL;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (COL != prev) changes++;
      prev = COL;
    end
    check("chord_scanning", 32'(changes >= 10), 32'd1);
    keys = 16'h0000;
    cyc(20);

    // CLR on the pulse cycle: entry cleared, code still reported.
    expect_press(4'hA, 1'b1);
    keys[10] = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1);
      if (KEY_VALID === 1'b1) found = 1'b1;
    end
    check("clr_pulse_found", 32'(found), 32'd1);
    CLR = 1'b1;
    cyc(1);
    CLR = 1'b0;
    cyc(40);
    keys = 16'h0000;
    cyc(30);
    wait_drain("clr_drain");

    // Reset while held in release: async return, then a fresh pulse.
    expect_press(4'h9, 1'b0);
    keys[9] = 1'b1;
    cyc(60);
    check("rel_drained", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("async_col", 32'(COL), 32'(4'b1110));
    check("async_valid", 32'(KEY_VALID), 32'd0);
    check("async_code", 32'(KEY_CODE), 32'd0);
    check("async_num", 32'(NUM), 32'd0);
    num_model = 0;
    @(negedge CLK);
    RST = 1'b0;
    expect_press(4'h9, 1'b0);
    cyc(60);
    wait_drain("rerun_drain");
    keys = 16'h0000;
    cyc(30);

    // Random key entries against the digit-shift model.
    for (int n = 0; n < 12; n++) begin
      press(4'($urandom_range(0, 15)), 45 + int'($urandom_range(0, 20)),
            25 + int'($urandom_range(0, 15)));
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
